// File: rtl/aes_8_bit_ct_collector.sv
// Receive-side collector for the aes_8_bit byte-serial ciphertext stream.
// Reassembles NBYTES bytes MSB-first into one block and offers it to the host
// through a single holding buffer with a valid/ready handshake. It also flags
// dropped blocks (ovf) and partial blocks that timed out (frag_err).
module aes_8_bit_ct_collector #(
    parameter  int NBYTES  = 16,
    parameter  int TIMEOUT = 64,
    parameter  int TO_W    = 7,
    localparam int BW      = 8 * NBYTES,
    localparam int CNT_W   = $clog2(NBYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d_in,
    input  logic             d_vld,
    input  logic [BW-1:0]    exp_ct,
    input  logic             clr,
    output logic [BW-1:0]    blk_data,
    output logic             blk_vld,
    input  logic             blk_rdy,
    output logic             blk_match,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             ovf,
    output logic             frag_err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state_q, state_d;
    logic [BW-9:0]    shift_q, shift_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [BW-1:0]    blk_data_q, blk_data_d;
    logic             blk_vld_q, blk_vld_d;
    logic             blk_match_q, blk_match_d;
    logic             ovf_q, ovf_d;
    logic             frag_q, frag_d;

    logic [BW-1:0]    full_blk;
    logic             last_byte;
    logic             complete;
    logic             timeout;

    // The block as it stands once the incoming byte is shifted in.
    assign full_blk  = {shift_q, d_in};
    assign last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));

    // Next-state logic: assembly, FSM and timeout, holding buffer, sticky flags.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        blk_data_d  = blk_data_q;
        blk_vld_d   = blk_vld_q;
        blk_match_d = blk_match_q;
        // A set event later in this block overrides the clear.
        ovf_d       = ovf_q & ~clr;
        frag_d      = frag_q & ~clr;
        complete    = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (d_vld) state_d = COLLECT;
            end
            COLLECT: begin
                if (d_vld) begin
                    // A byte arriving on the final idle cycle beats the timeout.
                    to_cnt_d = '0;
                    if (last_byte) state_d = IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (d_vld) begin
            shift_d = full_blk[BW-9:0];
            if (last_byte) begin
                complete   = 1'b1;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

        if (timeout) begin
            state_d    = IDLE;
            shift_d    = '0;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            frag_d     = 1'b1;
        end

        // The holding buffer frees on acceptance. A completion in the same
        // cycle refills it, so back-to-back blocks never stall.
        if (blk_vld_q && blk_rdy) blk_vld_d = 1'b0;
        if (complete) begin
            if (!blk_vld_q || blk_rdy) begin
                blk_data_d  = full_blk;
                blk_match_d = (full_blk == exp_ct);
                blk_vld_d   = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            blk_data_q  <= '0;
            blk_vld_q   <= 1'b0;
            blk_match_q <= 1'b0;
            ovf_q       <= 1'b0;
            frag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blk_data_q  <= blk_data_d;
            blk_vld_q   <= blk_vld_d;
            blk_match_q <= blk_match_d;
            ovf_q       <= ovf_d;
            frag_q      <= frag_d;
        end
    end

    assign blk_data  = blk_data_q;
    assign blk_vld   = blk_vld_q;
    assign blk_match = blk_match_q;
    assign byte_cnt  = byte_cnt_q;
    assign ovf       = ovf_q;
    assign frag_err  = frag_q;

endmodule

// File: tb/tb_aes_8_bit_ct_collector.sv
// Directed testbench for aes_8_bit_ct_collector using hand-computed vectors.
module tb_aes_8_bit_ct_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   d_in;
    logic         d_vld;
    logic [127:0] exp_ct;
    logic         clr;
    logic [127:0] blk_data;
    logic         blk_vld;
    logic         blk_rdy;
    logic         blk_match;
    logic [3:0]   byte_cnt;
    logic         ovf;
    logic         frag_err;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] VA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] VB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] VC = 128'h00112233445566778899aabbccddeeff;

    aes_8_bit_ct_collector dut (
        .clk(clk), .rst(rst), .d_in(d_in), .d_vld(d_vld), .exp_ct(exp_ct),
        .clr(clr), .blk_data(blk_data), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
        .blk_match(blk_match), .byte_cnt(byte_cnt), .ovf(ovf), .frag_err(frag_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, and checks happen there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        d_vld = 1'b1;
        d_in  = b;
        tick();
        d_vld = 1'b0;
        d_in  = 8'h00;
    endtask

    // Sends bytes [first..last] of v MSB-first, with gap idle cycles after each byte.
    task automatic send_range(input logic [127:0] v, input int first, input int last, input int gap);
        logic [127:0] t;
        t = v;
        for (int i = first; i <= last; i++) begin
            send_byte(t[127-8*i -: 8]);
            repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; d_in = 8'h00; d_vld = 1'b0; exp_ct = '0; clr = 1'b0; blk_rdy = 1'b0;
        #2;
        total++; if (blk_vld !== 1'b0 || ovf !== 1'b0 || frag_err !== 1'b0) begin bad++; $display("FAIL reset_flags got vld=%b ovf=%b frag=%b want 0", blk_vld, ovf, frag_err); end
        total++; if (blk_data !== 128'h0 || byte_cnt !== 4'd0 || blk_match !== 1'b0) begin bad++; $display("FAIL reset_data got data=%h cnt=%0d match=%b want 0", blk_data, byte_cnt, blk_match); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        blk_rdy = 1'b1; exp_ct = VA;
        send_range(VA, 0, 14, 0);
        total++; if (blk_vld !== 1'b0 || byte_cnt !== 4'd15) begin bad++; $display("FAIL basic_pre got vld=%b cnt=%0d want 0/15", blk_vld, byte_cnt); end
        send_range(VA, 15, 15, 0);
        total++; if (blk_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got %b want 1", blk_vld); end
        total++; if (blk_data !== VA) begin bad++; $display("FAIL basic_data got %h want %h", blk_data, VA); end
        total++; if (blk_match !== 1'b1 || byte_cnt !== 4'd0) begin bad++; $display("FAIL basic_match got match=%b cnt=%0d want 1/0", blk_match, byte_cnt); end
        tick();
        total++; if (blk_vld !== 1'b0) begin bad++; $display("FAIL basic_clear got %b want 0", blk_vld); end
    endtask

    task automatic test_gapped();
        blk_rdy = 1'b1; exp_ct = VB;
        send_range(VA, 0, 14, 2);
        send_range(VA, 15, 15, 0);
        total++; if (blk_vld !== 1'b1 || blk_data !== VA) begin bad++; $display("FAIL gap_data got vld=%b data=%h want 1/%h", blk_vld, blk_data, VA); end
        total++; if (blk_match !== 1'b0 || frag_err !== 1'b0) begin bad++; $display("FAIL gap_match got match=%b frag=%b want 0/0", blk_match, frag_err); end
        tick();
    endtask

    task automatic test_overflow();
        blk_rdy = 1'b0; exp_ct = VA;
        send_range(VA, 0, 15, 0);
        total++; if (blk_vld !== 1'b1 || blk_data !== VA || blk_match !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL ovf_a got vld=%b data=%h match=%b ovf=%b", blk_vld, blk_data, blk_match, ovf); end
        exp_ct = VB;
        send_range(VB, 0, 15, 0);
        total++; if (ovf !== 1'b1 || blk_data !== VA || blk_match !== 1'b1) begin bad++; $display("FAIL ovf_b got ovf=%b data=%h match=%b want 1/%h/1", ovf, blk_data, blk_match, VA); end
        send_range(VC, 0, 15, 0);
        total++; if (blk_data !== VA || blk_vld !== 1'b1) begin bad++; $display("FAIL ovf_c got data=%h vld=%b want %h/1", blk_data, blk_vld, VA); end
        blk_rdy = 1'b1;
        tick();
        blk_rdy = 1'b0;
        total++; if (blk_vld !== 1'b0 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_accept got vld=%b ovf=%b want 0/1", blk_vld, ovf); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got %b want 0", ovf); end
    endtask

    task automatic test_timeout();
        blk_rdy = 1'b1; exp_ct = VB;
        send_range(VA, 0, 6, 0);
        repeat (63) tick();
        total++; if (frag_err !== 1'b0 || byte_cnt !== 4'd7) begin bad++; $display("FAIL to_63 got frag=%b cnt=%0d want 0/7", frag_err, byte_cnt); end
        tick();
        total++; if (frag_err !== 1'b1 || byte_cnt !== 4'd0) begin bad++; $display("FAIL to_64 got frag=%b cnt=%0d want 1/0", frag_err, byte_cnt); end
        send_range(VB, 0, 15, 0);
        total++; if (blk_vld !== 1'b1 || blk_data !== VB || blk_match !== 1'b1) begin bad++; $display("FAIL to_next got vld=%b data=%h match=%b want 1/%h/1", blk_vld, blk_data, blk_match, VB); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (frag_err !== 1'b0) begin bad++; $display("FAIL to_clr got %b want 0", frag_err); end
        send_range(VC, 0, 6, 0);
        repeat (63) tick();
        send_range(VC, 7, 7, 0);
        total++; if (frag_err !== 1'b0 || byte_cnt !== 4'd8) begin bad++; $display("FAIL to_win got frag=%b cnt=%0d want 0/8", frag_err, byte_cnt); end
        send_range(VC, 8, 15, 0);
        total++; if (blk_data !== VC || blk_vld !== 1'b1) begin bad++; $display("FAIL to_win_blk got data=%h vld=%b want %h/1", blk_data, blk_vld, VC); end
        tick();
    endtask

    task automatic test_async_reset();
        blk_rdy = 1'b0; exp_ct = VA;
        send_range(VA, 0, 15, 0);
        send_range(VB, 0, 8, 0);
        total++; if (blk_vld !== 1'b1 || byte_cnt !== 4'd9) begin bad++; $display("FAIL ar_pre got vld=%b cnt=%0d want 1/9", blk_vld, byte_cnt); end
        #2 rst = 1'b0;
        #1;
        total++; if (blk_vld !== 1'b0 || byte_cnt !== 4'd0 || blk_data !== 128'h0 || blk_match !== 1'b0) begin bad++; $display("FAIL ar_async got vld=%b cnt=%0d data=%h match=%b want 0", blk_vld, byte_cnt, blk_data, blk_match); end
        tick();
        rst = 1'b1;
        blk_rdy = 1'b1; exp_ct = VC;
        send_range(VC, 0, 15, 0);
        total++; if (blk_vld !== 1'b1 || blk_data !== VC || blk_match !== 1'b1) begin bad++; $display("FAIL ar_after got vld=%b data=%h match=%b want 1/%h/1", blk_vld, blk_data, blk_match, VC); end
        tick();
    endtask

    task automatic test_back_to_back();
        blk_rdy = 1'b0; exp_ct = VA;
        send_range(VA, 0, 15, 0);
        exp_ct = VB;
        send_range(VB, 0, 14, 0);
        total++; if (blk_vld !== 1'b1 || blk_data !== VA) begin bad++; $display("FAIL b2b_hold got vld=%b data=%h want 1/%h", blk_vld, blk_data, VA); end
        blk_rdy = 1'b1;
        send_range(VB, 15, 15, 0);
        blk_rdy = 1'b0;
        total++; if (blk_vld !== 1'b1 || blk_data !== VB || blk_match !== 1'b1) begin bad++; $display("FAIL b2b_load got vld=%b data=%h match=%b want 1/%h/1", blk_vld, blk_data, blk_match, VB); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got %b want 0", ovf); end
        blk_rdy = 1'b1;
        exp_ct = VC;
        send_range(VC, 0, 15, 0);
        send_range(VA, 0, 15, 0);
        total++; if (ovf !== 1'b0 || blk_data !== VA || blk_match !== 1'b0) begin bad++; $display("FAIL b2b_stream got ovf=%b data=%h match=%b want 0/%h/0", ovf, blk_data, blk_match, VA); end
        tick();
        total++; if (blk_vld !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", blk_vld); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_8_bit_ct_collector.md
Name: aes_8_bit_ct_collector

Overview:
- Receive-side companion to aes_8_bit. Consumes the byte-serial ciphertext stream (d_out/d_vld) and reassembles it MSB-first into a 128-bit block.
- Presents each completed block to the host over a valid/ready handshake, with a one-block holding buffer.
- Optionally compares each block against an expected ciphertext.
- Flags overflow and fragmented (timed-out) blocks with sticky error bits.

Parameters:
- NBYTES, 16, bytes per block. Block width is 8*NBYTES.
- TIMEOUT, 64, idle cycles allowed between bytes of a partial block before it is discarded.
- TO_W, 7, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset). Released synchronously by the driving logic.
- d_in  in  8  ciphertext byte from aes_8_bit d_out.
- d_vld  in  1  byte strobe from aes_8_bit; one byte per cycle while high.
- exp_ct  in  128  expected ciphertext. Sampled on the cycle the last byte arrives.
- clr  in  1  synchronous clear of the sticky flags ovf and frag_err.
- blk_data  out  128  assembled block; first byte received sits in [127:120].
- blk_vld  out  1  holding buffer full.
- blk_rdy  in  1  host accepts the block when blk_vld && blk_rdy.
- blk_match  out  1  blk_data == exp_ct captured at completion; valid only while blk_vld.
- byte_cnt  out  4  bytes of the current partial block (0..15).
- ovf  out  1  sticky: a completed block was dropped because the holding buffer was full.
- frag_err  out  1  sticky: a partial block was discarded after timeout.

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0, the shift register clears, the counters clear, and the FSM goes to IDLE. Any partial block is lost.
- Assembly:
  - On each cycle with d_vld=1: shift_reg <= {shift_reg[119:0], d_in}, byte_cnt increments, and the timeout counter clears.
  - byte_cnt wraps 15 -> 0 on the 16th byte.
- FSM states: IDLE and COLLECT.
  - IDLE -> COLLECT on the first d_vld.
  - COLLECT -> IDLE when the 16th byte is taken, or on timeout.
  - In IDLE the timeout counter is held at 0.
- Completion: on the cycle the 16th byte is sampled, the full block is {shift_reg[119:0], d_in}.
  - If the holding buffer is empty, or is being accepted in the same cycle (blk_vld && blk_rdy), then on the next edge:
    - blk_data is loaded with the full block;
    - blk_match is loaded with (full block == exp_ct);
    - blk_vld is set to 1.
  - Latency is 1 cycle from the 16th d_vld to blk_vld.
  - If the holding buffer is full and not being accepted, the new block is dropped, ovf is set, and blk_data/blk_match/blk_vld are unchanged.
- Handshake:
  - blk_vld stays high, with blk_data stable, until accepted.
  - On acceptance with no simultaneous completion, blk_vld clears on the next edge.
  - Back-to-back blocks (16 consecutive d_vld, then 16 more) never overflow when blk_rdy is held at 1.
- Timeout: in COLLECT, each cycle with d_vld=0 increments the timeout counter.
  - When the counter reaches TIMEOUT: the partial block is discarded, byte_cnt goes to 0, the FSM returns to IDLE, and frag_err is set.
  - A d_vld on the same cycle the count reaches TIMEOUT wins: no timeout, and the byte is taken.
- Sticky flags: clr=1 clears ovf and frag_err on the next edge. A set event in the same cycle as clr wins, so the flag stays 1.
- Block assembly continues regardless of handshake state; the holding buffer is the only backpressure point, and there is no stall toward aes_8_bit.
- d_in is don't-care when d_vld=0.

Test Plan:
- Reset release, then 16 consecutive d_vld bytes 69,c4,e0,d8,6a,7b,04,30,d8,cd,b7,80,70,b4,c5,5a, with exp_ct=128'h69c4e0d86a7b0430d8cdb78070b4c55a and blk_rdy=1 -> blk_vld=1 exactly one cycle after the last byte, blk_data equals that value, blk_match=1, byte_cnt=0, and blk_vld clears the following cycle.
- Same byte stream with d_vld asserted every third cycle, exp_ct=128'h3925841d02dc09fbdc118597196a0b32 -> same blk_data, blk_match=0, no frag_err.
- blk_rdy=0 and three back-to-back blocks A, B, C -> blk_data=A held, ovf=1 after B completes, C also dropped. Then blk_rdy=1 -> A accepted. clr -> ovf=0.
- 7 bytes, then d_vld=0 for 64 cycles -> frag_err=1 and byte_cnt=0. A following 16-byte block assembles correctly with no stale bytes. Repeat with the next byte arriving at idle cycle 63 -> no frag_err, byte_cnt=8.
- rst=0 asserted after 9 bytes while blk_vld=1 -> all outputs 0 immediately, asynchronously. After release, a full 16-byte block yields the correct blk_data.
- Holding buffer full; blk_rdy pulsed high on the same cycle the next block's 16th byte arrives -> first block accepted, second loaded the next cycle, blk_vld stays 1, ovf=0.
